// File: rtl/maze_level_ctrl.sv
// Maze game level sequencer: moves IDLE -> PLAY -> LOSE/SCARE on frame boundaries,
// using per-frame hit/goal accumulators gathered from the pixel stream.
module maze_level_ctrl #(
  parameter int SCARE_FRAMES = 180,
  parameter int LOSE_FRAMES  = 60,
  parameter int GRACE_FRAMES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       frame_tick,
  input  logic       video_on,
  input  logic       start,
  input  logic       cursor_on,
  input  logic       path_on,
  input  logic       goal_on,
  output logic [1:0] level,
  output logic [1:0] state,
  output logic       scare_on,
  output logic       lose_on,
  output logic       level_up
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    PLAY  = 2'b01,
    LOSE  = 2'b10,
    SCARE = 2'b11
  } state_t;

  localparam logic [7:0] GRACE_CNT  = 8'(GRACE_FRAMES);
  localparam logic [7:0] LOSE_LAST  = 8'(LOSE_FRAMES - 1);
  localparam logic [7:0] SCARE_LAST = 8'(SCARE_FRAMES - 1);

  state_t     st;
  logic [7:0] frame_cnt;
  logic       hit_acc;
  logic       goal_acc;
  logic       grace;
  logic       hit_now;
  logic       goal_now;

  // The counter only runs during the early PLAY frames, so it doubles as the grace timer.
  assign grace    = (frame_cnt < GRACE_CNT);
  assign hit_now  = (st == PLAY) && !grace && video_on && cursor_on && !path_on;
  assign goal_now = (st == PLAY) && video_on && cursor_on && goal_on;
  assign state    = st;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st        <= IDLE;
      level     <= 2'd1;
      scare_on  <= 1'b0;
      lose_on   <= 1'b0;
      level_up  <= 1'b0;
      hit_acc   <= 1'b0;
      goal_acc  <= 1'b0;
      frame_cnt <= 8'd0;
    end else begin
      level_up <= 1'b0;

      // frame_tick only arrives with video_on=0, so no set can coincide with the clear.
      if (frame_tick) begin
        hit_acc  <= 1'b0;
        goal_acc <= 1'b0;
      end else begin
        if (hit_now)  hit_acc  <= 1'b1;
        if (goal_now) goal_acc <= 1'b1;
      end

      case (st)
        IDLE: begin
          level <= 2'd1;
          if (start) begin
            st        <= PLAY;
            frame_cnt <= 8'd0;
          end
        end

        PLAY: begin
          if (frame_tick) begin
            if (hit_acc) begin
              st        <= LOSE;
              lose_on   <= 1'b1;
              frame_cnt <= 8'd0;
            end else if (goal_acc) begin
              if (level != 2'd3) begin
                level     <= level + 2'd1;
                level_up  <= 1'b1;
                frame_cnt <= 8'd0;
              end else begin
                st        <= SCARE;
                scare_on  <= 1'b1;
                frame_cnt <= 8'd0;
              end
            end else if (grace) begin
              frame_cnt <= frame_cnt + 8'd1;
            end
          end
        end

        LOSE: begin
          if (frame_tick) begin
            if (frame_cnt == LOSE_LAST) begin
              st        <= PLAY;
              lose_on   <= 1'b0;
              level     <= 2'd1;
              frame_cnt <= 8'd0;
            end else begin
              frame_cnt <= frame_cnt + 8'd1;
            end
          end
        end

        SCARE: begin
          if (frame_tick) begin
            if (frame_cnt == SCARE_LAST) begin
              st        <= IDLE;
              scare_on  <= 1'b0;
              level     <= 2'd1;
              frame_cnt <= 8'd0;
            end else begin
              frame_cnt <= frame_cnt + 8'd1;
            end
          end
        end

        default: begin
          st        <= IDLE;
          level     <= 2'd1;
          scare_on  <= 1'b0;
          lose_on   <= 1'b0;
          frame_cnt <= 8'd0;
        end
      endcase
    end
  end

endmodule

// File: doc/maze_level_ctrl.md
MAZE_LEVEL_CTRL -- requirements
Module: maze_level_ctrl

Interface
REQ-001 Parameter SCARE_FRAMES, default 180: frames the scare screen is held.
REQ-002 Parameter LOSE_FRAMES, default 60: frames the lose screen is held.
REQ-003 Parameter GRACE_FRAMES, default 2: frames after each level load during which collisions are ignored.
REQ-004 Port clk  in  1  system clock; one clock drives every flop.
REQ-005 Port reset_n  in  1  reset, asynchronous assert, active-low.
REQ-006 Port frame_tick  in  1  one-cycle pulse once per frame, asserted only while video_on=0.
REQ-007 Port video_on  in  1  pixel is in the visible area.
REQ-008 Port start  in  1  debounced start pulse, one cycle.
REQ-009 Port cursor_on  in  1  current pixel lies inside the player cursor.
REQ-010 Port path_on  in  1  current pixel lies on the maze path (graph_on of the selected level).
REQ-011 Port goal_on  in  1  current pixel lies in the selected level's final box.
REQ-012 Port level  out  2  active level: 1, 2 or 3 (never 0); drives the level-graphics mux.
REQ-013 Port state  out  2  00 IDLE, 01 PLAY, 10 LOSE, 11 SCARE.
REQ-014 Port scare_on  out  1  high exactly while state=SCARE.
REQ-015 Port lose_on  out  1  high exactly while state=LOSE.
REQ-016 Port level_up  out  1  one-cycle pulse on each level advance.

Function
REQ-017 Hit accumulator: set on any cycle with state=PLAY, grace expired, video_on=1, cursor_on=1 and path_on=0.
REQ-018 Goal accumulator: set on any cycle with state=PLAY, video_on=1, cursor_on=1 and goal_on=1.
REQ-019 Both accumulators are evaluated and then cleared on frame_tick; they never carry over to the next frame.
REQ-020 The frame counter is 8 bits, increments on frame_tick in LOSE and SCARE and in PLAY while grace is active, and is cleared on every state or level change.
REQ-021 Grace is active while the frame counter is below GRACE_FRAMES after entering PLAY or a new level.
REQ-022 IDLE: level=1; start=1 -> PLAY, frame counter cleared.
REQ-023 PLAY, on frame_tick with hit set -> LOSE, regardless of goal.
REQ-024 PLAY, on frame_tick with goal set, no hit, level<3 -> level+1, level_up pulses in the following cycle, stays in PLAY with grace restarted.
REQ-025 PLAY, on frame_tick with goal set, no hit, level=3 -> SCARE.
REQ-026 LOSE: after LOSE_FRAMES frame_ticks -> PLAY with level=1 and grace restarted.
REQ-027 SCARE: after SCARE_FRAMES frame_ticks -> IDLE with level=1.
REQ-028 start is ignored in every state except IDLE.
REQ-029 frame_tick with neither accumulator set leaves state and level unchanged.
REQ-030 All outputs are registered; a transition is visible in the cycle after the frame_tick that causes it.

Reset
REQ-031 reset_n=0 immediately forces state=IDLE, level=1, scare_on=0, lose_on=0, level_up=0, accumulators=0 and frame counter=0, including in the middle of a frame or hold interval.
REQ-032 After reset_n is released, the block stays in IDLE until start is seen.

Verification
REQ-033 Reset, then start, then one frame with cursor_on=1, path_on=1, goal_on=1 -> level=2, level_up high for exactly 1 cycle, state=01.
REQ-034 In PLAY, cursor off-path during a grace frame, then on-path -> no LOSE; cursor off-path in frame 3 -> state=10 after that frame's frame_tick.
REQ-035 Hit and goal in the same frame at level 2 -> LOSE, level remains 2 until the hold ends; after 60 frame_ticks -> state=01, level=1.
REQ-036 Goal at level 3 -> state=11, scare_on=1 for 180 frame_ticks, then state=00, level=1; start pulses during SCARE are ignored.
REQ-037 Cursor off-path only while video_on=0 -> no hit is recorded.
REQ-038 reset_n asserted mid-SCARE with no clock edge -> outputs reach their reset values immediately (asynchronously).
